// File: rtl/mpu_regions_if.sv
// Check and config port bundle for the programmable MPU.
// The CPU side drives the chk_* signals and the bootloader drives the cfg_* signals.
interface mpu_regions_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  chk_valid;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic                  chk_write;
  logic                  chk_exec;
  logic                  chk_priv;
  logic                  chk_allowed;
  logic                  chk_violation;
  logic                  cfg_en;
  logic                  cfg_we;
  logic                  cfg_priv;
  logic [6:0]            cfg_addr;
  logic [31:0]           cfg_wdata;
  logic [31:0]           cfg_rdata;
  logic                  irq;

  modport master (
    output chk_valid, chk_addr, chk_write, chk_exec, chk_priv,
    output cfg_en, cfg_we, cfg_priv, cfg_addr, cfg_wdata,
    input  chk_allowed, chk_violation, cfg_rdata, irq
  );

  modport slave (
    input  chk_valid, chk_addr, chk_write, chk_exec, chk_priv,
    input  cfg_en, cfg_we, cfg_priv, cfg_addr, cfg_wdata,
    output chk_allowed, chk_violation, cfg_rdata, irq
  );
endinterface

// File: rtl/mpu_regions.sv
// Run-time programmable MPU: NUM_REGIONS address windows, default deny,
// first-fault capture, saturating violation counter and interrupt.
module mpu_regions #(
  parameter int unsigned NUM_REGIONS = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic          clk,
  input  logic          rst,
  mpu_regions_if.slave  bus
);
  localparam int unsigned AW     = ADDR_WIDTH;
  localparam int unsigned A_R    = 0;
  localparam int unsigned A_W    = 1;
  localparam int unsigned A_X    = 2;
  localparam int unsigned A_M    = 3;
  localparam int unsigned A_EN   = 4;
  localparam int unsigned A_LOCK = 5;

  logic [AW-1:0]        base_q  [NUM_REGIONS];
  logic [AW-1:0]        base_d  [NUM_REGIONS];
  logic [AW-1:0]        limit_q [NUM_REGIONS];
  logic [AW-1:0]        limit_d [NUM_REGIONS];
  logic [5:0]           attr_q  [NUM_REGIONS];
  logic [5:0]           attr_d  [NUM_REGIONS];
  logic [2:0]           ctrl_q, ctrl_d;
  logic [2:0]           sts_q, sts_d;
  logic [AW-1:0]        faddr_q, faddr_d;
  logic [6:0]           finfo_q, finfo_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 allow_q, viol_q, irq_q;

  logic       hit_c, perm_c, viol_c, allow_c;
  logic [3:0] hit_idx_c;
  logic [3:0] hit_attr_c;
  logic       cfg_wr_c, cfg_rd_c, cfg_fault_c, reg_sel_c;
  logic [3:0] reg_idx_c;

  // Lowest-index enabled window containing the address wins.
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = 4'hF;
    hit_attr_c = '0;
    for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
      if (attr_q[i][A_EN] && (base_q[i] <= bus.chk_addr) && (bus.chk_addr <= limit_q[i])) begin
        hit_c      = 1'b1;
        hit_idx_c  = 4'(i);
        hit_attr_c = attr_q[i][3:0];
      end
    end
    perm_c  = bus.chk_write ? hit_attr_c[A_W] :
              bus.chk_exec  ? hit_attr_c[A_X] : hit_attr_c[A_R];
    viol_c  = bus.chk_valid & ctrl_q[0] &
              (~hit_c | ~perm_c | (hit_attr_c[A_M] & ~bus.chk_priv));
    allow_c = bus.chk_valid & ~viol_c;
  end

  assign cfg_wr_c    = bus.cfg_en & bus.cfg_we & bus.cfg_priv;
  assign cfg_rd_c    = bus.cfg_en & ~bus.cfg_we;
  assign cfg_fault_c = bus.cfg_en & bus.cfg_we & ~bus.cfg_priv;
  assign reg_sel_c   = ~bus.cfg_addr[6] & (bus.cfg_addr[1:0] != 2'd3);
  assign reg_idx_c   = bus.cfg_addr[5:2];

  // Next-state for configuration, status, capture and read data.
  always_comb begin
    base_d  = base_q;
    limit_d = limit_q;
    attr_d  = attr_q;
    ctrl_d  = ctrl_q;
    sts_d   = sts_q;
    faddr_d = faddr_q;
    finfo_d = finfo_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    for (int i = 0; i < int'(NUM_REGIONS); i++) begin
      if (cfg_wr_c && reg_sel_c && (reg_idx_c == 4'(i)) && !attr_q[i][A_LOCK]) begin
        case (bus.cfg_addr[1:0])
          2'd0:    base_d[i]  = AW'(bus.cfg_wdata);
          2'd1:    limit_d[i] = AW'(bus.cfg_wdata);
          2'd2:    attr_d[i]  = {bus.cfg_wdata[31], bus.cfg_wdata[4:0]};
          default: ;
        endcase
      end
    end

    if (cfg_wr_c && (bus.cfg_addr == 7'h44) && !ctrl_q[2]) ctrl_d = bus.cfg_wdata[2:0];
    if (cfg_wr_c && (bus.cfg_addr == 7'h40)) sts_d = sts_q & ~bus.cfg_wdata[2:0];
    if (cfg_fault_c) sts_d[2] = 1'b1;

    // A clear in the same cycle re-arms capture for this violation.
    if (viol_c) begin
      if (!sts_d[0]) begin
        faddr_d  = bus.chk_addr;
        finfo_d  = {hit_idx_c, bus.chk_priv, bus.chk_exec, bus.chk_write};
        sts_d[0] = 1'b1;
      end else begin
        sts_d[1] = 1'b1;
      end
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (cfg_rd_c) begin
      rdata_d = '0;
      if (bus.cfg_priv) begin
        if (reg_sel_c) begin
          for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            if (reg_idx_c == 4'(i)) begin
              case (bus.cfg_addr[1:0])
                2'd0:    rdata_d = 32'(base_q[i]);
                2'd1:    rdata_d = 32'(limit_q[i]);
                2'd2:    rdata_d = {attr_q[i][A_LOCK], 26'd0, attr_q[i][4:0]};
                default: rdata_d = '0;
              endcase
            end
          end
        end else begin
          case (bus.cfg_addr)
            7'h40:   rdata_d = 32'(sts_q);
            7'h41:   rdata_d = 32'(faddr_q);
            7'h42:   rdata_d = {24'd0, finfo_q[6:3], 1'b0, finfo_q[2:0]};
            7'h43:   rdata_d = 32'(cnt_q);
            7'h44:   rdata_d = 32'(ctrl_q);
            default: rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '{default: '0};
      limit_q <= '{default: '0};
      attr_q  <= '{default: '0};
      ctrl_q  <= '0;
      sts_q   <= '0;
      faddr_q <= '0;
      finfo_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      allow_q <= 1'b0;
      viol_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      base_q  <= base_d;
      limit_q <= limit_d;
      attr_q  <= attr_d;
      ctrl_q  <= ctrl_d;
      sts_q   <= sts_d;
      faddr_q <= faddr_d;
      finfo_q <= finfo_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      allow_q <= allow_c;
      viol_q  <= viol_c;
      irq_q   <= sts_d[0] & ctrl_d[1];
    end
  end

  assign bus.chk_allowed   = allow_q;
  assign bus.chk_violation = viol_q;
  assign bus.cfg_rdata     = rdata_q;
  assign bus.irq           = irq_q;
endmodule
